// File: rtl/iob_ram_t2p_be_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_ram_t2p_be_arb: zero-fill sequencer and per-port round-robin arbiter    |
// | for a two-requester, byte-strobe, one-read/one-write-port RAM.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module iob_ram_t2p_be_arb #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  clr_start_i,
  output logic                  busy_o,
  input  logic                  a_valid_i,
  input  logic [ADDR_W-1:0]     a_addr_i,
  input  logic [DATA_W-1:0]     a_wdata_i,
  input  logic [DATA_W/8-1:0]   a_wstrb_i,
  output logic                  a_ready_o,
  output logic                  a_rvalid_o,
  output logic [DATA_W-1:0]     a_rdata_o,
  input  logic                  b_valid_i,
  input  logic [ADDR_W-1:0]     b_addr_i,
  input  logic [DATA_W-1:0]     b_wdata_i,
  input  logic [DATA_W/8-1:0]   b_wstrb_i,
  output logic                  b_ready_o,
  output logic                  b_rvalid_o,
  output logic [DATA_W-1:0]     b_rdata_o,
  output logic                  ram_r_en_o,
  output logic [ADDR_W-1:0]     ram_r_addr_o,
  input  logic [DATA_W-1:0]     ram_r_data_i,
  output logic [DATA_W/8-1:0]   ram_w_strb_o,
  output logic [ADDR_W-1:0]     ram_w_addr_o,
  output logic [DATA_W-1:0]     ram_w_data_o
);

  localparam int c_STRB_W = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rd_ptr;   // 0 = A has priority, 1 = B
  logic              r_wr_ptr;
  logic              r_a_rvalid;
  logic              r_b_rvalid;

  logic w_run;
  logic w_a_rd, w_a_wr, w_b_rd, w_b_wr;
  logic w_rd_gnt_a, w_rd_gnt_b, w_wr_gnt_a, w_wr_gnt_b;

  assign w_run  = (r_state == ST_RUN);
  assign w_a_rd = a_valid_i & ~(|a_wstrb_i);
  assign w_a_wr = a_valid_i &  (|a_wstrb_i);
  assign w_b_rd = b_valid_i & ~(|b_wstrb_i);
  assign w_b_wr = b_valid_i &  (|b_wstrb_i);

  // The pointer only decides when both requesters compete for the same port.
  assign w_rd_gnt_a = w_run & w_a_rd & (~w_b_rd | ~r_rd_ptr);
  assign w_rd_gnt_b = w_run & w_b_rd & (~w_a_rd |  r_rd_ptr);
  assign w_wr_gnt_a = w_run & w_a_wr & (~w_b_wr | ~r_wr_ptr);
  assign w_wr_gnt_b = w_run & w_b_wr & (~w_a_wr |  r_wr_ptr);

  assign a_ready_o    = w_rd_gnt_a | w_wr_gnt_a;
  assign b_ready_o    = w_rd_gnt_b | w_wr_gnt_b;
  assign busy_o       = ~w_run;
  assign a_rvalid_o   = r_a_rvalid;
  assign b_rvalid_o   = r_b_rvalid;
  assign a_rdata_o    = ram_r_data_i;
  assign b_rdata_o    = ram_r_data_i;
  assign ram_r_en_o   = w_rd_gnt_a | w_rd_gnt_b;
  assign ram_r_addr_o = w_rd_gnt_b ? b_addr_i : a_addr_i;

  always_comb begin
    ram_w_strb_o = '0;
    ram_w_addr_o = r_cnt;
    ram_w_data_o = '0;
    if (!w_run) begin
      ram_w_strb_o = {c_STRB_W{1'b1}};
    end else if (w_wr_gnt_a) begin
      ram_w_strb_o = a_wstrb_i;
      ram_w_addr_o = a_addr_i;
      ram_w_data_o = a_wdata_i;
    end else if (w_wr_gnt_b) begin
      ram_w_strb_o = b_wstrb_i;
      ram_w_addr_o = b_addr_i;
      ram_w_data_o = b_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_cnt      <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_rd_gnt_a;
      r_b_rvalid <= w_rd_gnt_b;
      if (w_rd_gnt_a | w_rd_gnt_b) begin
        if (w_a_rd & w_b_rd) r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_wr_gnt_a | w_wr_gnt_b) begin
        if (w_a_wr & w_b_wr) r_wr_ptr <= ~r_wr_ptr;
      end
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {ADDR_W{1'b1}}) r_state <= ST_RUN;
        end
        default: begin
          if (clr_start_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_ram_t2p_be_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iob_ram_t2p_be_arb: scoreboard bench with a behavioural read-old RAM.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_iob_ram_t2p_be_arb;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        clr_start_i;
  logic        busy_o;
  logic        a_valid_i, b_valid_i;
  logic [3:0]  a_addr_i, b_addr_i;
  logic [31:0] a_wdata_i, b_wdata_i;
  logic [3:0]  a_wstrb_i, b_wstrb_i;
  logic        a_ready_o, b_ready_o, a_rvalid_o, b_rvalid_o;
  logic [31:0] a_rdata_o, b_rdata_o;
  logic        ram_r_en_o;
  logic [3:0]  ram_r_addr_o;
  logic [31:0] ram_r_data_i;
  logic [3:0]  ram_w_strb_o;
  logic [3:0]  ram_w_addr_o;
  logic [31:0] ram_w_data_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] a_exp, b_exp;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic        a_rv_exp = 1'b0;
  logic        b_rv_exp = 1'b0;
  logic [31:0] mem[16];

  iob_ram_t2p_be_arb #(.ADDR_W(4), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .clr_start_i(clr_start_i), .busy_o(busy_o),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_wstrb_i(a_wstrb_i),
    .a_ready_o(a_ready_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_wstrb_i(b_wstrb_i),
    .b_ready_o(b_ready_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
    .ram_r_en_o(ram_r_en_o), .ram_r_addr_o(ram_r_addr_o), .ram_r_data_i(ram_r_data_i),
    .ram_w_strb_o(ram_w_strb_o), .ram_w_addr_o(ram_w_addr_o), .ram_w_data_o(ram_w_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RAM: registered read of the old contents, byte-strobed write.
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
  always @(posedge clk_i) begin
    if (ram_r_en_o) ram_r_data_i <= mem[ram_r_addr_o];
    for (int b = 0; b < 4; b++)
      if (ram_w_strb_o[b]) mem[ram_w_addr_o][8*b +: 8] <= ram_w_data_o[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: accepted reads push their expected data, rvalid pops and compares.
  always @(negedge clk_i) begin
    if (arst_i) begin
      qa.delete();
      qb.delete();
      a_rv_exp = 1'b0;
      b_rv_exp = 1'b0;
    end else begin
      check("a_rvalid", a_rvalid_o, a_rv_exp);
      check("b_rvalid", b_rvalid_o, b_rv_exp);
      if (a_rvalid_o && qa.size() > 0) check("a_rdata", a_rdata_o, qa.pop_front());
      if (b_rvalid_o && qb.size() > 0) check("b_rdata", b_rdata_o, qb.pop_front());
      a_rv_exp = a_valid_i && a_ready_o && (a_wstrb_i == 4'h0);
      b_rv_exp = b_valid_i && b_ready_o && (b_wstrb_i == 4'h0);
      if (a_rv_exp) qa.push_back(a_exp);
      if (b_rv_exp) qb.push_back(b_exp);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [3:0] ad, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] ex);
    a_valid_i = v; a_addr_i = ad; a_wdata_i = wd; a_wstrb_i = st; a_exp = ex;
  endtask

  task automatic drv_b(input logic v, input logic [3:0] ad, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] ex);
    b_valid_i = v; b_addr_i = ad; b_wdata_i = wd; b_wstrb_i = st; b_exp = ex;
  endtask

  task automatic fill_run(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 64) begin
      check({tag, "_waddr"}, ram_w_addr_o, n[3:0]);
      check({tag, "_wstrb"}, ram_w_strb_o, 4'hF);
      check({tag, "_wdata"}, ram_w_data_o, 32'h0);
      check({tag, "_ren"}, ram_r_en_o, 1'b0);
      check({tag, "_rdy"}, {a_ready_o, b_ready_o}, 2'b00);
      n++;
      tick();
      #1;
    end
    check({tag, "_cycles"}, n, 16);
  endtask

  initial begin
    arst_i = 1'b1;
    clr_start_i = 1'b0;
    drv_a(1'b1, 4'h7, 32'h0, 4'h0, 32'h0);
    drv_b(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_busy", busy_o, 1'b1);
    check("rst_rvalid", {a_rvalid_o, b_rvalid_o}, 2'b00);
    check("rst_waddr", ram_w_addr_o, 4'h0);
    arst_i = 1'b0;

    // Reset fill; A's read of 0x7 waits across the whole fill.
    fill_run("fill_rst");
    check("post_fill_a_rdy", a_ready_o, 1'b1);
    tick();
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    // Read contention alternates A,B,A,B.
    tick();
    drv_a(1'b1, 4'h2, 32'h0, 4'h0, 32'h0);
    drv_b(1'b1, 4'h5, 32'h0, 4'h0, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_a_rdy", a_ready_o, (i % 2) == 0);
      check("rr_b_rdy", b_ready_o, (i % 2) == 1);
      check("rr_raddr", ram_r_addr_o, (i % 2) ? 4'h5 : 4'h2);
      tick();
      #1;
    end
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    drv_b(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    // Concurrent write by A and read by B of the same address.
    tick();
    drv_a(1'b1, 4'h3, 32'h12345678, 4'hF, 32'h0);
    drv_b(1'b1, 4'h3, 32'h0, 4'h0, 32'h0);
    #1;
    check("conc_rdy", {a_ready_o, b_ready_o}, 2'b11);
    check("conc_waddr", ram_w_addr_o, 4'h3);
    tick();
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    drv_b(1'b1, 4'h3, 32'h0, 4'h0, 32'h12345678);
    #1;
    check("conc_b_rdy2", b_ready_o, 1'b1);
    tick();
    drv_b(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    // Byte strobes 0x5.
    tick();
    drv_b(1'b1, 4'h9, 32'hAABBCCDD, 4'h5, 32'h0);
    #1;
    check("be_b_rdy", b_ready_o, 1'b1);
    check("be_wstrb", ram_w_strb_o, 4'h5);
    tick();
    drv_b(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    drv_a(1'b1, 4'h9, 32'h0, 4'h0, 32'h00BB00DD);
    #1;
    check("be_a_rdy", a_ready_o, 1'b1);
    tick();
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    // Write contention: A first, then B; B's value survives.
    tick();
    drv_a(1'b1, 4'h4, 32'h1, 4'hF, 32'h0);
    drv_b(1'b1, 4'h4, 32'h2, 4'hF, 32'h0);
    #1;
    check("wc_rdy1", {a_ready_o, b_ready_o}, 2'b10);
    check("wc_wdata1", ram_w_data_o, 32'h1);
    tick();
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    #1;
    check("wc_rdy2", b_ready_o, 1'b1);
    check("wc_wdata2", ram_w_data_o, 32'h2);
    tick();
    drv_b(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    drv_a(1'b1, 4'h4, 32'h0, 4'h0, 32'h2);
    tick();
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    // clr_start with a read granted in the same cycle.
    tick();
    drv_a(1'b1, 4'h1, 32'hFFFFFFFF, 4'hF, 32'h0);
    #1;
    check("clr_wr_rdy", a_ready_o, 1'b1);
    tick();
    drv_a(1'b1, 4'h1, 32'h0, 4'h0, 32'hFFFFFFFF);
    clr_start_i = 1'b1;
    #1;
    check("clr_rd_rdy", a_ready_o, 1'b1);
    tick();
    clr_start_i = 1'b0;
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    drv_b(1'b1, 4'h1, 32'h0, 4'h0, 32'h0);
    #1;
    fill_run("fill_clr");
    check("post_clr_b_rdy", b_ready_o, 1'b1);
    tick();
    drv_b(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    // Reset in the middle of a fill restarts it from address 0.
    tick();
    clr_start_i = 1'b1;
    tick();
    clr_start_i = 1'b0;
    #1;
    begin
      int n;
      n = 0;
      while (ram_w_addr_o != 4'h5 && n < 64) begin
        tick();
        #1;
        n++;
      end
    end
    check("mid_addr5", ram_w_addr_o, 4'h5);
    arst_i = 1'b1;
    #1;
    check("mid_rst_busy", busy_o, 1'b1);
    check("mid_rst_waddr", ram_w_addr_o, 4'h0);
    tick();
    arst_i = 1'b0;
    #1;
    fill_run("fill_mid");
    tick();
    drv_a(1'b1, 4'h1, 32'h0, 4'h0, 32'h0);
    tick();
    drv_a(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);

    repeat (3) tick();
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
